// File: rtl/vram_write_scheduler.sv
// VRAM write scheduler: queues CPU writes and commits them in FIFO order
// only while video timing reports the writable (vblank) window.
module vram_write_scheduler #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 16,
  parameter int SEL_W  = 6
) (
  input  logic                       gpu_clk,
  input  logic                       rst,
  input  logic                       writable_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [ADDR_W-1:0]          req_address_i,
  input  logic [7:0]                 req_data_i,
  input  logic [SEL_W-1:0]           req_select_i,
  output logic                       wr_en_o,
  output logic [ADDR_W-1:0]          wr_address_o,
  output logic [7:0]                 wr_data_o,
  output logic [SEL_W-1:0]           wr_select_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       pending_o,
  output logic                       overflow_o,
  input  logic                       clr_overflow_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [7:0]        data;
    logic [SEL_W-1:0]  select;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;
  logic          drop;

  assign req_ready_o = count < CW'(DEPTH);
  // select==0 requests are ignored entirely, even when full
  assign push = req_valid_i && req_ready_o && (|req_select_i);
  assign drop = req_valid_i && !req_ready_o && (|req_select_i);
  assign pop  = writable_i && (count != '0);
  assign count_o = count;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CW'(1);
    else if (!push && pop)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge gpu_clk) begin
    if (push)
      mem[wptr] <= '{req_address_i, req_data_i, req_select_i};
  end

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      pending_o    <= 1'b0;
      wr_en_o      <= 1'b0;
      wr_address_o <= '0;
      wr_data_o    <= '0;
      wr_select_o  <= '0;
      overflow_o   <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + PW'(1);
      if (pop)
        rptr <= rptr + PW'(1);
      count     <= count_nxt;
      pending_o <= count_nxt != '0;
      if (pop) begin
        wr_en_o      <= 1'b1;
        wr_address_o <= mem[rptr].address;
        wr_data_o    <= mem[rptr].data;
        wr_select_o  <= mem[rptr].select;
      end else begin
        wr_en_o     <= 1'b0;
        wr_select_o <= '0;
      end
      // a fresh drop beats a simultaneous clear
      if (drop)
        overflow_o <= 1'b1;
      else if (clr_overflow_i)
        overflow_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Bench for vram_write_scheduler: queue model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_vram_write_scheduler;

  localparam int DEPTH = 16;

  logic        gpu_clk = 1'b0;
  logic        rst = 1'b1;
  logic        writable_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [15:0] req_address_i = '0;
  logic [7:0]  req_data_i = '0;
  logic [5:0]  req_select_i = '0;
  logic        wr_en_o;
  logic [15:0] wr_address_o;
  logic [7:0]  wr_data_o;
  logic [5:0]  wr_select_o;
  logic [4:0]  count_o;
  logic        pending_o;
  logic        overflow_o;
  logic        clr_overflow_i = 1'b0;

  vram_write_scheduler #(.DEPTH(DEPTH), .ADDR_W(16), .SEL_W(6)) dut (
    .gpu_clk(gpu_clk), .rst(rst), .writable_i(writable_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_address_i(req_address_i), .req_data_i(req_data_i),
    .req_select_i(req_select_i), .wr_en_o(wr_en_o),
    .wr_address_o(wr_address_o), .wr_data_o(wr_data_o),
    .wr_select_o(wr_select_o), .count_o(count_o),
    .pending_o(pending_o), .overflow_o(overflow_o),
    .clr_overflow_i(clr_overflow_i)
  );

  always #5 gpu_clk = ~gpu_clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic [5:0]  s;
    int          cyc;
  } wr_t;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  bit  chk_en = 0;
  wr_t model_q[$];
  wr_t dut_log[$];

  logic        exp_en, exp_ovf;
  logic [15:0] exp_a;
  logic [7:0]  exp_d;
  logic [5:0]  exp_s;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: a plain queue with the window/overflow rules
  always @(posedge gpu_clk) begin
    wr_t e;
    bit  rdy;
    bit  dropped;
    if (rst) begin
      model_q.delete();
      exp_en = 0; exp_a = '0; exp_d = '0; exp_s = '0; exp_ovf = 0;
    end else begin
      rdy = model_q.size() < DEPTH;
      dropped = 0;
      if (writable_i && model_q.size() > 0) begin
        e = model_q.pop_front();
        exp_en = 1; exp_a = e.a; exp_d = e.d; exp_s = e.s;
      end else begin
        exp_en = 0; exp_s = '0;
      end
      if (req_valid_i && req_select_i != 0) begin
        if (rdy) begin
          e.a = req_address_i; e.d = req_data_i;
          e.s = req_select_i; e.cyc = 0;
          model_q.push_back(e);
        end else begin
          dropped = 1;
        end
      end
      if (dropped) exp_ovf = 1;
      else if (clr_overflow_i) exp_ovf = 0;
    end
  end

  always @(negedge gpu_clk) begin
    logic [38:0] act, exp;
    wr_t w;
    cyc++;
    if (chk_en) begin
      act = {req_ready_o, wr_en_o, wr_select_o, wr_address_o,
             wr_data_o, count_o, pending_o, overflow_o};
      exp = {model_q.size() < DEPTH, exp_en, exp_s, exp_a, exp_d,
             5'(model_q.size()), model_q.size() != 0, exp_ovf};
      check("cycle", 64'(act), 64'(exp));
      if (wr_en_o) begin
        w.a = wr_address_o; w.d = wr_data_o;
        w.s = wr_select_o; w.cyc = cyc;
        dut_log.push_back(w);
      end
    end
  end

  task automatic push(input logic [15:0] a, input logic [7:0] d,
                      input logic [5:0] s);
    req_valid_i = 1; req_address_i = a;
    req_data_i = d; req_select_i = s;
    @(negedge gpu_clk);
    req_valid_i = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge gpu_clk);
  endtask

  initial begin
    int bad;
    rst = 1;
    ticks(2);
    chk_en = 1;
    rst = 0;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_ready", 64'(req_ready_o), 64'd1);
    check("rst_wren", 64'(wr_en_o), 64'd0);
    check("rst_addr", 64'(wr_address_o), 64'd0);

    // three queued writes held until window opens
    push(16'h0010, 8'hAA, 6'b100000);
    push(16'h0011, 8'hBB, 6'b000010);
    push(16'h0200, 8'hCC, 6'b010000);
    ticks(2);
    check("t1_count", 64'(count_o), 64'd3);
    check("t1_wren", 64'(wr_en_o), 64'd0);
    dut_log.delete();
    writable_i = 1;
    ticks(4);
    writable_i = 0;
    check("t1_n", 64'(dut_log.size()), 64'd3);
    if (dut_log.size() == 3) begin
      check("t1_w0", {dut_log[0].a, dut_log[0].d, dut_log[0].s},
            {16'h0010, 8'hAA, 6'b100000});
      check("t1_w1", {dut_log[1].a, dut_log[1].d, dut_log[1].s},
            {16'h0011, 8'hBB, 6'b000010});
      check("t1_w2", {dut_log[2].a, dut_log[2].d, dut_log[2].s},
            {16'h0200, 8'hCC, 6'b010000});
      check("t1_back2back", 64'(dut_log[2].cyc - dut_log[0].cyc), 64'd2);
    end
    check("t1_empty", {count_o, pending_o}, 64'd0);

    // latency through an empty FIFO
    writable_i = 1;
    push(16'h0042, 8'h5A, 6'b001000);
    check("t2_edgeN", 64'(wr_en_o), 64'd0);
    ticks(1);
    check("t2_edgeN1", {wr_en_o, wr_address_o, wr_data_o, wr_select_o},
          {1'b1, 16'h0042, 8'h5A, 6'b001000});
    ticks(1);
    check("t2_after", 64'(wr_en_o), 64'd0);
    writable_i = 0;

    // fill, overflow, clear/drop interplay
    for (int i = 0; i < DEPTH; i++)
      push(16'h1000 + 16'(i), 8'(i), 6'(1 << (i % 6)));
    check("t3_full", {req_ready_o, count_o}, {1'b0, 5'd16});
    push(16'hDEAD, 8'hEE, 6'b000001);
    check("t3_ovf", 64'(overflow_o), 64'd1);
    clr_overflow_i = 1;
    push(16'hDEAD, 8'hEF, 6'b000001);
    clr_overflow_i = 0;
    check("t3_setwins", 64'(overflow_o), 64'd1);
    clr_overflow_i = 1;
    ticks(1);
    clr_overflow_i = 0;
    check("t3_clr", 64'(overflow_o), 64'd0);
    push(16'hBEEF, 8'h00, 6'b000000);
    check("t3_sel0", 64'(overflow_o), 64'd0);
    dut_log.delete();
    writable_i = 1;
    ticks(18);
    writable_i = 0;
    check("t3_n", 64'(dut_log.size()), 64'd16);
    if (dut_log.size() == 16) begin
      check("t3_w0", {dut_log[0].a, dut_log[0].d, dut_log[0].s},
            {16'h1000, 8'h00, 6'b000001});
      check("t3_w15", {dut_log[15].a, dut_log[15].d, dut_log[15].s},
            {16'h100F, 8'h0F, 6'b001000});
    end
    bad = 0;
    foreach (dut_log[i])
      if (dut_log[i].a == 16'hDEAD || dut_log[i].a == 16'hBEEF) bad++;
    check("t3_nodrop", 64'(bad), 64'd0);

    // window closes after three writes
    for (int i = 0; i < 8; i++)
      push(16'h2000 + 16'(i), 8'h20 + 8'(i), 6'b000100);
    dut_log.delete();
    writable_i = 1;
    ticks(3);
    writable_i = 0;
    ticks(3);
    check("t4_n1", 64'(dut_log.size()), 64'd3);
    check("t4_left", 64'(count_o), 64'd5);
    writable_i = 1;
    ticks(7);
    writable_i = 0;
    check("t4_n2", 64'(dut_log.size()), 64'd8);
    if (dut_log.size() == 8) begin
      check("t4_w3", 64'(dut_log[3].a), 64'h2003);
      check("t4_w7", 64'(dut_log[7].a), 64'h2007);
    end

    // streaming push+pop across pointer wrap
    dut_log.delete();
    writable_i = 1;
    for (int i = 0; i < 40; i++) begin
      req_valid_i = 1;
      req_address_i = 16'h3000 + 16'(i);
      req_data_i = 8'(i);
      req_select_i = 6'(1 << (i % 6));
      ticks(1);
    end
    req_valid_i = 0;
    check("t5_count", {count_o, overflow_o}, {5'd1, 1'b0});
    ticks(3);
    writable_i = 0;
    check("t5_n", 64'(dut_log.size()), 64'd40);
    if (dut_log.size() == 40)
      check("t5_last", 64'(dut_log[39].a), 64'h3027);

    // reset mid-drain
    for (int i = 0; i < 8; i++)
      push(16'h4000 + 16'(i), 8'h40, 6'b000001);
    writable_i = 1;
    ticks(2);
    rst = 1;
    ticks(1);
    check("t6_rst", {wr_en_o, count_o, pending_o}, 64'd0);
    rst = 0;
    dut_log.delete();
    ticks(5);
    writable_i = 0;
    check("t6_stale", 64'(dut_log.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
